// File: rtl/bridge_arbiter.sv
// Two-master (M0 CPU, M1 DMA) arbiter in front of the system bridge: round-robin with locked bursts.
// Define ARB_FIXED_PRIO_EN for fixed M0 priority: M0 wins ties and cuts M1 bursts short.
module bridge_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int WAIT_CYC  = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [3:0]        bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    // state  | meaning
    // IDLE   | bus free, arbitrate between pending requests
    // ACCESS | owner's transaction on the bus for WAIT_CYC cycles
    // DONE   | one-cycle done pulse to owner, decide burst continuation
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic [3:0]          wait_cnt;
    logic [3:0]          burst_cnt;
    logic [3:0]          lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                win;
    logic                src;
    logic [3:0]          src_we;
    logic [ADDR_W-1:0]   src_addr;
    logic [DATA_W-1:0]   src_wdata;
    logic                owner_req;
    logic                owner_lock;
    logic                preempt;
    logic                burst_go;

    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

    always_comb begin
        win = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        win     = ~m0_req;
        preempt = owner & m0_req;
`else
        if (m0_req && m1_req)
            win = ~last_grant;
        else
            win = ~m0_req;
        preempt = 1'b0;
`endif
        src        = (state == IDLE) ? win : owner;
        src_we     = src ? m1_we    : m0_we;
        src_addr   = src ? m1_addr  : m0_addr;
        src_wdata  = src ? m1_wdata : m0_wdata;
        owner_req  = owner ? m1_req  : m0_req;
        owner_lock = owner ? m1_lock : m0_lock;
        burst_go   = owner_req && owner_lock && (burst_cnt < BURST_LIM) && !preempt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
            burst_cnt  <= 4'd0;
            lat_we     <= 4'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            bus_we     <= 4'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state     <= ACCESS;
                        owner     <= win;
                        lat_we    <= src_we;
                        lat_addr  <= src_addr;
                        lat_wdata <= src_wdata;
                        bus_we    <= src_we;
                        wait_cnt  <= 4'd0;
                        m0_gnt    <= ~win;
                        m1_gnt    <= win;
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    // write strobe lasts only the first access cycle
                    bus_we <= 4'd0;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= DONE;
                        if (owner)
                            m1_rdata <= bus_rdata;
                        else
                            m0_rdata <= bus_rdata;
                        m0_done <= ~owner;
                        m1_done <= owner;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    m0_done <= 1'b0;
                    m1_done <= 1'b0;
                    if (burst_go) begin
                        state     <= ACCESS;
                        lat_we    <= src_we;
                        lat_addr  <= src_addr;
                        lat_wdata <= src_wdata;
                        bus_we    <= src_we;
                        wait_cnt  <= 4'd0;
                        burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        state      <= IDLE;
                        last_grant <= owner;
                        burst_cnt  <= 4'd0;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter: WAIT_CYC=1 instance (u_dut1) and WAIT_CYC=3 instance (u_dut3).
module tb_bridge_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m1_req = 0, m0_lock = 0, m1_lock = 0;
    logic        d3_m0_req = 0, d3_m1_req = 0;
    logic [3:0]  m0_we = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic [31:0] bus_rdata = 0;

    logic        d1_m0_gnt, d1_m0_done, d1_m1_gnt, d1_m1_done, d1_busy;
    logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_bus_addr, d1_bus_wdata;
    logic [3:0]  d1_bus_we;
    logic        d3_m0_gnt, d3_m0_done, d3_m1_gnt, d3_m1_done, d3_busy;
    logic [31:0] d3_m0_rdata, d3_m1_rdata, d3_bus_addr, d3_bus_wdata;
    logic [3:0]  d3_bus_we;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic [31:0] other;
        int          cyc;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] mod1[2];
    logic [31:0] mod3[2];

`ifdef ARB_FIXED_PRIO_EN
    localparam int ALT = 0;
`else
    localparam int ALT = 1;
`endif

    bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1), .MAX_BURST(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(d1_m0_gnt), .m0_done(d1_m0_done), .m0_rdata(d1_m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(d1_m1_gnt), .m1_done(d1_m1_done), .m1_rdata(d1_m1_rdata),
        .bus_we(d1_bus_we), .bus_addr(d1_bus_addr), .bus_wdata(d1_bus_wdata),
        .bus_rdata(bus_rdata), .busy(d1_busy)
    );

    bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(3), .MAX_BURST(4)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(d3_m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(d3_m0_gnt), .m0_done(d3_m0_done), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(d3_m1_gnt), .m1_done(d3_m1_done), .m1_rdata(d3_m1_rdata),
        .bus_we(d3_bus_we), .bus_addr(d3_bus_addr), .bus_wdata(d3_bus_wdata),
        .bus_rdata(bus_rdata), .busy(d3_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int m, input logic [31:0] rd, input int c);
        exp_t e;
        e.m   = m;
        e.rd  = rd;
        e.cyc = c;
        if (d == 1) begin
            e.other = mod1[1-m];
            mod1[m] = rd;
            q1.push_back(e);
        end else begin
            e.other = mod3[1-m];
            mod3[m] = rd;
            q3.push_back(e);
        end
    endtask

    task automatic handle(input int d, input int m, input logic [31:0] rd0, input logic [31:0] rd1,
                          input logic g0, input logic g1);
        exp_t e;
        check($sformatf("d%0d_done_has_gnt", d), m ? g1 : g0, 1);
        if ((d == 1 && q1.size() == 0) || (d == 3 && q3.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL d%0d_unexpected_done: got done from M%0d expected none (cycle %0d)", d, m, cyc);
        end else begin
            e = (d == 1) ? q1.pop_front() : q3.pop_front();
            check($sformatf("d%0d_done_master", d), m, e.m);
            check($sformatf("d%0d_done_cycle", d), cyc, e.cyc);
            check($sformatf("d%0d_owner_rdata", d), m ? rd1 : rd0, e.rd);
            check($sformatf("d%0d_other_rdata", d), m ? rd0 : rd1, e.other);
        end
    endtask

    always @(negedge clk) begin
        check("d1_gnt_exclusive", d1_m0_gnt & d1_m1_gnt, 0);
        check("d3_gnt_exclusive", d3_m0_gnt & d3_m1_gnt, 0);
        if (d1_m0_done || d1_m1_done)
            handle(1, d1_m1_done ? 1 : 0, d1_m0_rdata, d1_m1_rdata, d1_m0_gnt, d1_m1_gnt);
        if (d3_m0_done || d3_m1_done)
            handle(3, d3_m1_done ? 1 : 0, d3_m0_rdata, d3_m1_rdata, d3_m0_gnt, d3_m1_gnt);
    end

    task automatic next_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic check_d1_zero(input string tag);
        check({tag, "_d1_outs"}, {d1_m0_gnt, d1_m0_done, d1_m1_gnt, d1_m1_done, d1_busy, d1_bus_we}, 0);
        check({tag, "_d1_rdata"}, {d1_m0_rdata, d1_m1_rdata}, 0);
        check({tag, "_d1_bus"}, {d1_bus_addr, d1_bus_wdata}, 0);
    endtask

    task automatic check_d3_zero(input string tag);
        check({tag, "_d3_outs"}, {d3_m0_gnt, d3_m0_done, d3_m1_gnt, d3_m1_done, d3_busy, d3_bus_we}, 0);
        check({tag, "_d3_rdata"}, {d3_m0_rdata, d3_m1_rdata}, 0);
        check({tag, "_d3_bus"}, {d3_bus_addr, d3_bus_wdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        mod1[0] = 0; mod1[1] = 0; mod3[0] = 0; mod3[1] = 0;
        repeat (2) @(negedge clk);
        check_d1_zero("reset");
        check_d3_zero("reset");
        reset_n = 1'b1;
        goto_neg(cyc + 2);

        // single M0 write
        next_pos; c = cyc;
        m0_req = 1; m0_we = 4'hF; m0_addr = 32'h7f04; m0_wdata = 32'h0000_0010;
        push(1, 0, bus_rdata, c + 2);
        goto_neg(c + 1);
        check("wr_bus_we_first", d1_bus_we, 4'hF);
        check("wr_bus_addr", d1_bus_addr, 32'h7f04);
        check("wr_bus_wdata", d1_bus_wdata, 32'h10);
        check("wr_m0_gnt_busy", {d1_m0_gnt, d1_m1_gnt, d1_busy}, 3'b101);
        goto_neg(c + 2);
        check("wr_bus_we_done", d1_bus_we, 0);
        check("wr_m1_gnt", d1_m1_gnt, 0);
        m0_req = 0; m0_we = 0;
        goto_neg(c + 4);
        check("idle_busy", d1_busy, 0);
        check("idle_addr_hold", d1_bus_addr, 32'h7f04);

        // M1 read
        next_pos; c = cyc;
        bus_rdata = 32'hDEAD_BEEF;
        m1_req = 1; m1_we = 0; m1_addr = 32'h7f20;
        push(1, 1, 32'hDEAD_BEEF, c + 2);
        goto_neg(c + 2);
        m1_req = 0;
        goto_neg(c + 4);

        // both request continuously, no lock
        next_pos; c = cyc;
        bus_rdata = 32'h1234_5678;
        m0_req = 1; m1_req = 1; m0_addr = 32'h7f08; m1_addr = 32'h7f0c;
        push(1, 0,   32'h1234_5678, c + 2);
        push(1, ALT, 32'h1234_5678, c + 5);
        push(1, 0,   32'h1234_5678, c + 8);
        push(1, ALT, 32'h1234_5678, c + 11);
        goto_neg(c + 11);
        m0_req = 0; m1_req = 0;
        goto_neg(c + 13);

        // M0 locked burst against a waiting M1
        next_pos; c = cyc;
        bus_rdata = 32'hCAFE_0001;
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) push(1, 0, 32'hCAFE_0001, c + 2 + 2 * i);
        push(1, ALT, 32'hCAFE_0001, c + 11);
        goto_neg(c + 11);
        m0_req = 0; m0_lock = 0; m1_req = 0;
        goto_neg(c + 13);

        // WAIT_CYC=3 write
        next_pos; c = cyc;
        bus_rdata = 32'h5A5A_0000;
        d3_m0_req = 1; m0_we = 4'hF; m0_addr = 32'h7f10; m0_wdata = 32'h55;
        push(3, 0, 32'h5A5A_0000, c + 4);
        goto_neg(c + 1);
        check("w3_bus_we_a1", d3_bus_we, 4'hF);
        check("w3_bus_addr", d3_bus_addr, 32'h7f10);
        goto_neg(c + 2);
        check("w3_bus_we_a2", {d3_bus_we, d3_m0_gnt, d3_m0_done}, 6'b0000_10);
        goto_neg(c + 3);
        check("w3_bus_we_a3", {d3_bus_we, d3_m0_gnt, d3_m0_done}, 6'b0000_10);
        goto_neg(c + 4);
        d3_m0_req = 0; m0_we = 0;
        goto_neg(c + 6);

        // reset during second ACCESS cycle
        next_pos; c = cyc;
        d3_m0_req = 1; m0_we = 4'h3; m0_addr = 32'h7f14; m0_wdata = 32'h99;
        goto_neg(c + 2);
        check("rst_pre_we_off", {d3_bus_we, d3_m0_gnt}, 5'b0000_1);
        reset_n = 1'b0;
        #1;
        check_d3_zero("midrst");
        d3_m0_req = 0; m0_we = 0;
        mod1[0] = 0; mod1[1] = 0; mod3[0] = 0; mod3[1] = 0;
        goto_neg(c + 4);
        reset_n = 1'b1;
        next_pos; c = cyc;
        bus_rdata = 32'hABCD_0123;
        d3_m0_req = 1; d3_m1_req = 1;
        push(3, 0, 32'hABCD_0123, c + 4);
        goto_neg(c + 4);
        d3_m0_req = 0; d3_m1_req = 0;
        goto_neg(c + 8);

        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
